// File: rtl/apb_master_if.sv
// apb_master_if: command/response channels plus the APB bus of apb_master.
// master = initiator view, slave = command source / APB slave view.
interface apb_master_if #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int STRB_WD = 4,
  parameter int PROT_WD = 3
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [ADDR_WD-1:0] cmd_addr;
  logic [DATA_WD-1:0] cmd_wdata;
  logic [STRB_WD-1:0] cmd_strb;
  logic [PROT_WD-1:0] cmd_prot;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_WD-1:0] rsp_rdata;
  logic               rsp_err;
  logic               b_psel;
  logic               b_penable;
  logic               b_pwrite;
  logic [ADDR_WD-1:0] b_paddr;
  logic [DATA_WD-1:0] b_pwdata;
  logic [STRB_WD-1:0] b_pstrb;
  logic [PROT_WD-1:0] b_pprot;
  logic [DATA_WD-1:0] b_prdata;
  logic               b_pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr,
    input  cmd_wdata, cmd_strb, cmd_prot,
    input  rsp_ready, b_prdata, b_pready,
    output cmd_ready, rsp_valid, rsp_rdata,
    output rsp_err, b_psel, b_penable,
    output b_pwrite, b_paddr, b_pwdata,
    output b_pstrb, b_pprot
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr,
    output cmd_wdata, cmd_strb, cmd_prot,
    output rsp_ready, b_prdata, b_pready,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  rsp_err, b_psel, b_penable,
    input  b_pwrite, b_paddr, b_pwdata,
    input  b_pstrb, b_pprot
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: one APB SETUP/ACCESS transfer per command, wait-state timeout.
// Ports: b_pclk, b_prst_n (async low), bus (apb_master_if.master).
module apb_master #(
  parameter int ADDR_WD     = 32,
  parameter int DATA_WD     = 32,
  parameter int STRB_WD     = 4,
  parameter int PROT_WD     = 3,
  parameter int TIMEOUT_CYC = 256
) (
  input logic          b_pclk,
  input logic          b_prst_n,
  apb_master_if.master bus
);

  localparam int CNT_WD =
    (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_WD-1:0] TERM =
    CNT_WD'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_WD-1:0]  cnt_q, cnt_d;
  logic               rdy_q, rdy_d;
  logic               psel_q, psel_d;
  logic               pen_q, pen_d;
  logic               pwr_q, pwr_d;
  logic [ADDR_WD-1:0] paddr_q, paddr_d;
  logic [DATA_WD-1:0] pwdata_q, pwdata_d;
  logic [STRB_WD-1:0] pstrb_q, pstrb_d;
  logic [PROT_WD-1:0] pprot_q, pprot_d;
  logic               rvld_q, rvld_d;
  logic [DATA_WD-1:0] rdata_q, rdata_d;
  logic               rerr_q, rerr_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdy_d    = rdy_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwr_d    = pwr_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
    rvld_d   = rvld_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    unique case (state_q)
      IDLE: begin
        // rdy_q is low for one cycle after reset
        rdy_d = 1'b1;
        if (rdy_q && bus.cmd_valid) begin
          state_d  = SETUP;
          rdy_d    = 1'b0;
          psel_d   = 1'b1;
          pen_d    = 1'b0;
          cnt_d    = '0;
          pwr_d    = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          pprot_d  = bus.cmd_prot;
          pstrb_d  = bus.cmd_write ?
                     bus.cmd_strb : '0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        pen_d   = 1'b1;
      end
      ACCESS: begin
        // pready beats a same-cycle timeout
        if (bus.b_pready) begin
          state_d = RESP;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rvld_d  = 1'b1;
          rerr_d  = 1'b0;
          rdata_d = pwr_q ? '0 : bus.b_prdata;
        end else if (TO_EN && cnt_q == TERM) begin
          state_d = RESP;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rvld_d  = 1'b1;
          rerr_d  = 1'b1;
          rdata_d = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_WD'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rvld_d  = 1'b0;
          rdy_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge b_pclk or negedge b_prst_n) begin
    if (!b_prst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwr_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      rvld_q   <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwr_q    <= pwr_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
      rvld_q   <= rvld_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  assign bus.cmd_ready = rdy_q;
  assign bus.b_psel    = psel_q;
  assign bus.b_penable = pen_q;
  assign bus.b_pwrite  = pwr_q;
  assign bus.b_paddr   = paddr_q;
  assign bus.b_pwdata  = pwdata_q;
  assign bus.b_pstrb   = pstrb_q;
  assign bus.b_pprot   = pprot_q;
  assign bus.rsp_valid = rvld_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rerr_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed + random transfers against a cycle-count model.
// Slave wait states, timeouts, backpressure and reset are driven from here.
module tb_apb_master;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_master_if bus ();

  apb_master #(
    .TIMEOUT_CYC(TO)
  ) dut (
    .b_pclk  (clk),
    .b_prst_n(rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] rdat;
    int          waits;
    int          stall;
    logic        hold;
  } cmd_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag,
                     logic [127:0] got,
                     logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ctl();
    return {bus.cmd_ready, bus.b_psel,
            bus.b_penable, bus.rsp_valid};
  endfunction

  function automatic logic [127:0] pay();
    return 128'({bus.b_pwrite, bus.b_paddr,
                 bus.b_pwdata, bus.b_pstrb,
                 bus.b_pprot});
  endfunction

  function automatic cmd_t mk(
    logic wr, logic [31:0] addr,
    logic [31:0] wdata, logic [3:0] strb,
    logic [2:0] prot, logic [31:0] rdat,
    int waits, int stall, logic hold);
    cmd_t c;
    c.wr = wr; c.addr = addr;
    c.wdata = wdata; c.strb = strb;
    c.prot = prot; c.rdat = rdat;
    c.waits = waits; c.stall = stall;
    c.hold = hold;
    return c;
  endfunction

  // Called at a falling edge with the DUT idle.
  task automatic xfer(cmd_t c);
    int          n_acc;
    logic        err;
    logic [31:0] rd;
    logic [127:0] ep;
    int          g;
    // Slave answers on ACCESS cycle waits+1
    // unless the timeout ends ACCESS first.
    err   = (c.waits >= TO);
    n_acc = err ? TO : c.waits + 1;
    rd    = (c.wr || err) ? 32'h0 : c.rdat;
    ep    = 128'({c.wr, c.addr, c.wdata,
                  c.wr ? c.strb : 4'h0, c.prot});
    bus.cmd_write = c.wr;
    bus.cmd_addr  = c.addr;
    bus.cmd_wdata = c.wdata;
    bus.cmd_strb  = c.strb;
    bus.cmd_prot  = c.prot;
    bus.cmd_valid = 1'b1;
    bus.b_pready  = 1'($urandom);
    bus.b_prdata  = $urandom;
    g = 0;
    while (!bus.cmd_ready && g < 8) begin
      @(negedge clk);
      g++;
    end
    chk("cmd_ready", 128'(bus.cmd_ready), 128'(1));
    @(negedge clk);
    bus.cmd_valid = c.hold;
    chk("setup_ctl", 128'(ctl()), 128'(4'b0100));
    chk("setup_pay", pay(), ep);
    for (int k = 0; k < n_acc; k++) begin
      @(negedge clk);
      chk("acc_ctl", 128'(ctl()), 128'(4'b0110));
      chk("acc_pay", pay(), ep);
      bus.b_pready = (k == c.waits);
      bus.b_prdata = (k == c.waits) ?
                     c.rdat : $urandom;
    end
    @(negedge clk);
    bus.b_pready = 1'($urandom);
    bus.b_prdata = $urandom;
    chk("resp_ctl", 128'(ctl()), 128'(4'b0001));
    chk("rsp_rdata", 128'(bus.rsp_rdata), 128'(rd));
    chk("rsp_err", 128'(bus.rsp_err), 128'(err));
    repeat (c.stall) begin
      @(negedge clk);
      chk("bp_ctl", 128'(ctl()), 128'(4'b0001));
      chk("bp_rsp",
          128'({bus.rsp_err, bus.rsp_rdata}),
          128'({err, rd}));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("idle_ctl", 128'(ctl()), 128'(4'b1000));
    chk("idle_pay", pay(), ep);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.rsp_ready = 1'b0;
    bus.b_pready  = 1'b0;
    bus.b_prdata  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 128'(ctl()), 128'(0));
    chk("rst_pay", pay(), 128'(0));
    chk("rst_rsp",
        128'({bus.rsp_err, bus.rsp_rdata}),
        128'(0));
    rst_n = 1'b1;
    #1;
    chk("rel_rdy0", 128'(bus.cmd_ready), 128'(0));
    @(negedge clk);
    chk("rel_rdy1", 128'(bus.cmd_ready), 128'(1));

    xfer(mk(1'b1, 32'h4000_0010, 32'hDEAD_BEEF,
            4'hF, 3'd0, 32'h0, 0, 0, 1'b0));
    xfer(mk(1'b0, 32'hC000_0004, 32'h0,
            4'hF, 3'd2, 32'h1234_5678, 3, 0, 1'b0));
    xfer(mk(1'b0, 32'h0000_0100, 32'h5,
            4'h3, 3'd1, 32'hBAD0_BAD0, 1000, 0, 1'b0));
    xfer(mk(1'b1, 32'h0000_0104, 32'hCAFE_F00D,
            4'h5, 3'd0, 32'h0, 0, 0, 1'b0));
    xfer(mk(1'b0, 32'h0000_0200, 32'h0,
            4'h0, 3'd7, 32'hA5A5_5A5A, 1, 5, 1'b1));
    xfer(mk(1'b1, 32'h0000_0204, 32'h1111_2222,
            4'hC, 3'd3, 32'h0, 0, 0, 1'b0));
    xfer(mk(1'b0, 32'h0000_0300, 32'h0,
            4'hF, 3'd0, 32'h7777_8888, TO - 1, 0, 1'b0));

    // Reset in the middle of ACCESS.
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0000_0400;
    bus.cmd_wdata = 32'hFFFF_0000;
    bus.cmd_strb  = 4'hF;
    bus.cmd_prot  = 3'd5;
    bus.cmd_valid = 1'b1;
    bus.b_pready  = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_ctl", 128'(ctl()), 128'(4'b0110));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", 128'(ctl()), 128'(0));
    chk("arst_pay", pay(), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arel_rdy0", 128'(bus.cmd_ready), 128'(0));
    @(negedge clk);
    chk("arel_rdy1", 128'(bus.cmd_ready), 128'(1));

    for (int i = 0; i < 40; i++) begin
      c = mk(1'($urandom), $urandom, $urandom,
             4'($urandom), 3'($urandom), $urandom,
             int'($urandom_range(0, TO + 3)),
             int'($urandom_range(0, 3)),
             (i < 39) ? 1'($urandom) : 1'b0);
      xfer(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
